// File: rtl/mult_share_scheduler.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier between two clients.
// Operands are captured on grant; the result returns with a one-cycle done pulse.
module mult_share_scheduler #(
    parameter int TIMEOUT = 12
) (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res,
    output logic        err,
    output logic        busy,
    output logic        owner,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [15:0] mult_product
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic        last_grant, last_d;
    logic        sel;
    logic        ack0_d, ack1_d, done0_d, done1_d;
    logic [15:0] res_d;
    logic        err_d, busy_d, owner_d, start_d;
    logic [7:0]  dataa_d, datab_d;

    // On a tie, the client that was not granted last time wins.
    assign sel = (req0 && req1) ? ~last_grant : req1;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last_grant;
        owner_d = owner;
        dataa_d = mult_dataa;
        datab_d = mult_datab;
        res_d   = res;
        err_d   = err;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        start_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = START;
                    owner_d = sel;
                    last_d  = sel;
                    dataa_d = sel ? a1 : a0;
                    datab_d = sel ? b1 : b0;
                    ack0_d  = ~sel;
                    ack1_d  = sel;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
                // A done seen at count 0 may be left over from the previous op.
                if (mult_done && cnt != 8'd0) begin
                    state_d = RESP;
                    res_d   = mult_product;
                    err_d   = 1'b0;
                    done0_d = ~owner;
                    done1_d = owner;
                end else if (cnt >= TO) begin
                    state_d = RESP;
                    res_d   = 16'h0000;
                    err_d   = 1'b1;
                    done0_d = ~owner;
                    done1_d = owner;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            mult_dataa <= 8'd0;
            mult_datab <= 8'd0;
            res        <= 16'h0000;
            err        <= 1'b0;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            mult_start <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            last_grant <= last_d;
            owner      <= owner_d;
            mult_dataa <= dataa_d;
            mult_datab <= datab_d;
            res        <= res_d;
            err        <= err_d;
            busy       <= busy_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            done0      <= done0_d;
            done1      <= done1_d;
            mult_start <= start_d;
        end
    end

endmodule

// File: doc/mult_share_scheduler.md
# mult_share_scheduler

Two-requester round-robin scheduler that shares one 8x8 sequential multiplier, the 4x4-partial-product unit driven by its own controller, between two client blocks. Accepts an operand pair per request, drives the multiplier's operand inputs and start strobe, waits for completion (with timeout), and returns the 16-bit product to the granted requester with a one-cycle done pulse. Sits between the clients and the multiplier top level.

## Interface
- TIMEOUT, 12, WAIT-state cycles allowed before an operation is aborted with error; legal range 2..255
- clk  in  1  system clock, rising edge
- aclr_n  in  1  asynchronous active-low reset
- req0, req1  in  1  request from client 0/1; sampled only in IDLE
- a0, b0, a1, b1  in  8  operands of client 0/1, valid while matching req is high
- ack0, ack1  out  1  one-cycle pulse: operands captured, request accepted
- done0, done1  out  1  one-cycle pulse: result on res/err valid for that client
- res  out  16  product of last completed operation, held until next RESP
- err  out  1  last operation timed out (res = 16'h0000); held like res
- busy  out  1  high in every state except IDLE
- owner  out  1  client index of current/last grant
- mult_dataa, mult_datab  out  8  operands to multiplier, stable from START through RESP
- mult_start  out  1  one-cycle start strobe to multiplier
- mult_done  in  1  multiplier done flag (level; may remain high from previous op)
- mult_product  in  16  multiplier result, valid while mult_done high

## Operation
- FSM states: IDLE, START, WAIT, RESP. All outputs registered.
- IDLE: if any req high, arbitrate, capture selected a/b into mult_dataa/datab, set owner, go START. Else stay.
- Arbitration: only one req -> that one. Both -> the client not equal to last_grant. last_grant resets to 1 so client 0 wins first tie; updated on entry to START.
- START (1 cycle): ack[owner]=1, mult_start=1, timeout counter cleared; go WAIT.
- WAIT: counter increments every cycle (saturates at 255). mult_done ignored while counter = 0 (first WAIT cycle, masks stale done). mult_done=1 with counter >= 1 -> latch mult_product into res, err=0, go RESP. Counter reaching TIMEOUT without done -> res=0, err=1, go RESP. done and timeout in same cycle: done wins.
- RESP (1 cycle): done[owner]=1; go IDLE.
- Client rule: req high in IDLE means a new operation. Client drops req no later than the cycle after its ack unless issuing another operation.
- mult_dataa/datab hold captured values until next capture; never change during START/WAIT/RESP.
- Reset (any state, asynchronous): state IDLE, all outputs 0 (res 16'h0000, err 0, owner 0, busy 0, mult_start 0, acks/dones 0, mult_dataa/datab 0), counter 0, last_grant 1. In-flight operation is discarded; no done pulse.

## Timing
- Request seen in IDLE at edge E0 -> ack and mult_start high in cycle after E0 (START).
- First WAIT cycle has counter 0; earliest accepted done is second WAIT cycle.
- Result latched at edge where WAIT sees done; done pulse and new res visible next cycle (RESP).
- Minimum req-to-done latency: 4 cycles plus multiplier latency beyond its first done-sampling cycle; back-to-back ops: one IDLE cycle between RESP and next START.
- Timeout: done pulse with err=1 appears TIMEOUT+2 cycles after START.
- busy high from START through RESP inclusive.

## Test plan
- req0, a0=8'hFF, b0=8'hFF, model asserts done 5 cycles after start -> ack0 one cycle with mult_start, mult_dataa/datab=FF/FF, done0 pulse, res=16'hFE01, err=0, done1/ack1 never high.
- req0 (3x4) and req1 (5x6) same cycle after reset -> client 0 served first (res=16'h000C, owner 0), then client 1 (res=16'h001E, owner 1).
- req1 held continuously, req0 raised during client 1's WAIT -> grants alternate 1,0,1; neither client starved.
- Model holds mult_done high from prior op through START and first WAIT cycle, drops, raises 4 cycles later with new product -> no early RESP; res equals new product.
- Model never asserts done, TIMEOUT=12 -> done0 pulse 14 cycles after START with err=1, res=0; subsequent request completes normally with err=0.
- aclr_n pulsed low mid-WAIT -> all outputs 0 immediately, no done pulse; req0 still high after release -> fresh ack0, mult_start, correct result.
